// File: rtl/ps2_ascii_stream.sv
// ps2_ascii_stream
// Turns raw PS/2 set-2 scan bytes into case-correct ASCII characters.
// A small prefix FSM tracks the F0 (break) and E0 (extended) prefixes.
// Shift and caps-lock state are kept here as well.
// Characters are queued in a show-ahead FIFO with a valid/ready handshake.
// Optional build macro: PS2_REPEAT_FILTER_EN. When defined, a make code that
// repeats the last character-producing make (typematic repeat) is suppressed.
module ps2_ascii_stream #(
  parameter int FIFO_DEPTH   = 8,
  parameter int CAPS_DEFAULT = 0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [7:0]                      scan_code,
  input  logic                            scan_valid,
  output logic [7:0]                      ascii_data,
  output logic                            ascii_valid,
  input  logic                            ascii_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow,
  input  logic                            clr_overflow,
  output logic                            shift_active,
  output logic                            caps_lock
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0] ZERO_PTR = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);
  localparam logic             CAPS_RST = (CAPS_DEFAULT != 0);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } state_t;

  // Bytes the receiver may deliver that carry no key information
  // (errors, BAT result, ACK, resend, pause prefix).
  function automatic logic is_ignored(input logic [7:0] code);
    logic res;
    case (code)
      8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF: res = 1'b1;
      default:                                  res = 1'b0;
    endcase
    return res;
  endfunction

  // Character lookup for a make event. Result is {valid, character}.
  function automatic logic [8:0] map_char(input logic [7:0] code,
                                          input logic       ext,
                                          input logic       shift,
                                          input logic       caps);
    logic [7:0] letter;
    logic       is_letter;
    logic [7:0] digit;
    logic [7:0] sym;
    logic       is_digit;
    logic [8:0] res;
    is_letter = 1'b1;
    case (code)
      8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
      8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
      8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
      default: begin
        letter    = 8'h00;
        is_letter = 1'b0;
      end
    endcase
    is_digit = 1'b1;
    case (code)
      8'h45: begin digit = 8'h30; sym = 8'h29; end  // 0 )
      8'h16: begin digit = 8'h31; sym = 8'h21; end  // 1 !
      8'h1E: begin digit = 8'h32; sym = 8'h40; end  // 2 @
      8'h26: begin digit = 8'h33; sym = 8'h23; end  // 3 #
      8'h25: begin digit = 8'h34; sym = 8'h24; end  // 4 $
      8'h2E: begin digit = 8'h35; sym = 8'h25; end  // 5 %
      8'h36: begin digit = 8'h36; sym = 8'h5E; end  // 6 ^
      8'h3D: begin digit = 8'h37; sym = 8'h26; end  // 7 &
      8'h3E: begin digit = 8'h38; sym = 8'h2A; end  // 8 *
      8'h46: begin digit = 8'h39; sym = 8'h28; end  // 9 (
      default: begin
        digit    = 8'h00;
        sym      = 8'h00;
        is_digit = 1'b0;
      end
    endcase
    if (ext) begin
      case (code)
        8'h5A:   res = {1'b1, 8'h0D};   // keypad enter
        8'h4A:   res = {1'b1, 8'h2F};   // keypad slash
        default: res = 9'h000;
      endcase
    end else if (is_letter) begin
      // Letter table holds lowercase; uppercase is 0x20 below.
      res = {1'b1, (shift ^ caps) ? (letter - 8'h20) : letter};
    end else if (is_digit) begin
      // Caps lock deliberately has no effect on the digit row.
      res = {1'b1, shift ? sym : digit};
    end else begin
      case (code)
        8'h29:   res = {1'b1, 8'h20};   // space
        8'h5A:   res = {1'b1, 8'h0D};   // enter
        8'h66:   res = {1'b1, 8'h08};   // backspace
        8'h0D:   res = {1'b1, 8'h09};   // tab
        default: res = 9'h000;
      endcase
    end
    return res;
  endfunction

`ifdef PS2_REPEAT_FILTER_EN
  // Shift and caps keys never disturb the repeat filter memory.
  function automatic logic is_modifier(input logic [7:0] code);
    logic res;
    case (code)
      8'h12, 8'h59, 8'h58: res = 1'b1;
      default:             res = 1'b0;
    endcase
    return res;
  endfunction
`endif

  // Decoder / modifier state
  state_t     state_q, state_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic       caps_q, caps_d;
  logic       caps_held_q, caps_held_d;
  logic       shift_act_q;
  logic       make_s, brk_s, ext_s;
  logic [8:0] map_s;
  logic       push_req_s;
  logic [7:0] push_char_s;

`ifdef PS2_REPEAT_FILTER_EN
  logic       last_valid_q, last_valid_d;
  logic       last_ext_q, last_ext_d;
  logic [7:0] last_code_q, last_code_d;
  logic       last_match_s;
`endif

  // FIFO state
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       head_q, head_d;
  logic             valid_q, valid_d;
  logic             pop_s, full_s, push_ok_s;

  // Prefix FSM: classify each received byte as ignored, prefix, make or break.
  always_comb begin
    state_d = state_q;
    make_s  = 1'b0;
    brk_s   = 1'b0;
    ext_s   = 1'b0;
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == 8'hF0) begin
            state_d = ST_BREAK;
          end else if (scan_code == 8'hE0) begin
            state_d = ST_EXT;
          end else if (is_ignored(scan_code)) begin
            state_d = ST_IDLE;
          end else begin
            make_s  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BREAK: begin
          brk_s   = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT: begin
          if (scan_code == 8'hF0) begin
            state_d = ST_EXT_BREAK;
          end else begin
            make_s  = 1'b1;
            ext_s   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_EXT_BREAK: begin
          // Extended break: only the repeat filter looks at it.
          brk_s   = 1'b1;
          ext_s   = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Modifier tracking: shift-held bits and caps lock with a held bit so
  // typematic repeats of the caps key do not toggle it again.
  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    if (make_s && !ext_s) begin
      case (scan_code)
        8'h12: lshift_d = 1'b1;
        8'h59: rshift_d = 1'b1;
        8'h58: begin
          caps_held_d = 1'b1;
          if (!caps_held_q) begin
            caps_d = ~caps_q;
          end else begin
            caps_d = caps_q;
          end
        end
        default: lshift_d = lshift_q;
      endcase
    end else if (brk_s && !ext_s) begin
      case (scan_code)
        8'h12:   lshift_d    = 1'b0;
        8'h59:   rshift_d    = 1'b0;
        8'h58:   caps_held_d = 1'b0;
        default: lshift_d    = lshift_q;
      endcase
    end else begin
      lshift_d = lshift_q;
    end
  end

  // Character generation for make events, with optional repeat suppression.
  always_comb begin
    map_s       = map_char(scan_code, ext_s, lshift_q | rshift_q, caps_q);
    push_char_s = map_s[7:0];
    push_req_s  = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
    last_valid_d = last_valid_q;
    last_ext_d   = last_ext_q;
    last_code_d  = last_code_q;
    last_match_s = last_valid_q && (last_code_q == scan_code) && (last_ext_q == ext_s);
    if (make_s && map_s[8]) begin
      if (last_match_s) begin
        push_req_s = 1'b0;
      end else begin
        push_req_s   = 1'b1;
        last_valid_d = 1'b1;
        last_ext_d   = ext_s;
        last_code_d  = scan_code;
      end
    end else if (make_s && (ext_s || !is_modifier(scan_code))) begin
      // A different non-character key interrupts the repeat run.
      last_valid_d = 1'b0;
    end else if (brk_s && last_match_s) begin
      last_valid_d = 1'b0;
    end else begin
      last_valid_d = last_valid_q;
    end
`else
    push_req_s = make_s && map_s[8];
`endif
  end

  // FIFO control: pointers, occupancy, sticky overflow and the next head.
  always_comb begin
    pop_s     = (count_q != ZERO_CNT) && ascii_ready;
    full_s    = (count_q == FULL_CNT);
    push_ok_s = push_req_s && (!full_s || pop_s);
    wr_ptr_d  = push_ok_s ? (wr_ptr_q + ONE_PTR) : wr_ptr_q;
    rd_ptr_d  = pop_s ? (rd_ptr_q + ONE_PTR) : rd_ptr_q;
    if (push_ok_s && !pop_s) begin
      count_d = count_q + ONE_CNT;
    end else if (!push_ok_s && pop_s) begin
      count_d = count_q - ONE_CNT;
    end else begin
      count_d = count_q;
    end
    // A drop takes priority over a simultaneous clear.
    if (push_req_s && full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    valid_d = (count_d != ZERO_CNT);
    // The new head may be the character being written this very cycle.
    if (count_d == ZERO_CNT) begin
      head_d = 8'h00;
    end else if (push_ok_s && (rd_ptr_d == wr_ptr_q)) begin
      head_d = push_char_s;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Character storage; stale entries are harmless because pointers reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_char_s;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= CAPS_RST;
      caps_held_q <= 1'b0;
      shift_act_q <= 1'b0;
      wr_ptr_q    <= ZERO_PTR;
      rd_ptr_q    <= ZERO_PTR;
      count_q     <= ZERO_CNT;
      overflow_q  <= 1'b0;
      head_q      <= 8'h00;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      shift_act_q <= lshift_d | rshift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      head_q      <= head_d;
      valid_q     <= valid_d;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  // Repeat filter memory: last character-producing make code.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_valid_q <= 1'b0;
      last_ext_q   <= 1'b0;
      last_code_q  <= 8'h00;
    end else begin
      last_valid_q <= last_valid_d;
      last_ext_q   <= last_ext_d;
      last_code_q  <= last_code_d;
    end
  end
`endif

  assign ascii_data   = head_q;
  assign ascii_valid  = valid_q;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign shift_active = shift_act_q;
  assign caps_lock    = caps_q;

endmodule

// File: tb/tb_ps2_ascii_stream.sv
// Directed, table-driven bench for ps2_ascii_stream (default parameters).
module tb_ps2_ascii_stream;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int NV    = 33;

  logic          clk          = 1'b0;
  logic          reset_n      = 1'b0;
  logic [7:0]    scan_code    = 8'h00;
  logic          scan_valid   = 1'b0;
  logic          ascii_ready  = 1'b0;
  logic          clr_overflow = 1'b0;
  logic [7:0]    ascii_data;
  logic          ascii_valid;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          shift_active;
  logic          caps_lock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int             nb;
    logic [3:0][7:0] b;
    int             nch;
    logic [7:0]     ch;
    logic           sh;
    logic           cp;
  } vec_t;

  vec_t       vec [NV];
  logic [7:0] expq [$];

  // Free-running clock.
  always #5 clk = ~clk;

  ps2_ascii_stream #(.FIFO_DEPTH(DEPTH), .CAPS_DEFAULT(0)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .scan_code    (scan_code),
    .scan_valid   (scan_valid),
    .ascii_data   (ascii_data),
    .ascii_valid  (ascii_valid),
    .ascii_ready  (ascii_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .shift_active (shift_active),
    .caps_lock    (caps_lock)
  );

  function automatic vec_t mk(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input int nch, input logic [7:0] ch,
                              input logic sh, input logic cp);
    vec_t v;
    v.nb  = nb;
    v.b   = {8'h00, b2, b1, b0};
    v.nch = nch;
    v.ch  = ch;
    v.sh  = sh;
    v.cp  = cp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic pop1();
    @(negedge clk);
    ascii_ready = 1'b1;
    @(negedge clk);
    ascii_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = expq.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s valid[%0d]", tag, i), {31'd0, ascii_valid}, 32'd1);
      chk($sformatf("%s data[%0d]", tag, i), {24'd0, ascii_data}, {24'd0, expq[i]});
      pop1();
    end
    expq.delete();
    chk({tag, " empty count"}, 32'(fifo_count), 32'd0);
    chk({tag, " empty valid"}, {31'd0, ascii_valid}, 32'd0);
    chk({tag, " empty data"}, {24'd0, ascii_data}, 32'd0);
  endtask

  initial begin
    logic [7:0] letters [9];
    logic [7:0] codes   [9];
    int         exp_rep;

    vec[0]  = mk(3, 8'h1C, 8'hF0, 8'h1C, 1, 8'h61, 1'b0, 1'b0);
    vec[1]  = mk(1, 8'h12, 8'h00, 8'h00, 0, 8'h00, 1'b1, 1'b0);
    vec[2]  = mk(1, 8'h1C, 8'h00, 8'h00, 1, 8'h41, 1'b1, 1'b0);
    vec[3]  = mk(2, 8'hF0, 8'h1C, 8'h00, 0, 8'h00, 1'b1, 1'b0);
    vec[4]  = mk(2, 8'hF0, 8'h12, 8'h00, 0, 8'h00, 1'b0, 1'b0);
    vec[5]  = mk(3, 8'h58, 8'hF0, 8'h58, 0, 8'h00, 1'b0, 1'b1);
    vec[6]  = mk(3, 8'h1C, 8'hF0, 8'h1C, 1, 8'h41, 1'b0, 1'b1);
    vec[7]  = mk(2, 8'h12, 8'h1C, 8'h00, 1, 8'h61, 1'b1, 1'b1);
    vec[8]  = mk(1, 8'h16, 8'h00, 8'h00, 1, 8'h21, 1'b1, 1'b1);
    vec[9]  = mk(2, 8'hF0, 8'h12, 8'h00, 0, 8'h00, 1'b0, 1'b1);
    vec[10] = mk(3, 8'hF0, 8'h16, 8'h16, 1, 8'h31, 1'b0, 1'b1);
    vec[11] = mk(1, 8'h58, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b0);
    vec[12] = mk(1, 8'h58, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b0);
    vec[13] = mk(2, 8'hF0, 8'h58, 8'h00, 0, 8'h00, 1'b0, 1'b0);
    vec[14] = mk(2, 8'hE0, 8'h5A, 8'h00, 1, 8'h0D, 1'b0, 1'b0);
    vec[15] = mk(3, 8'hE0, 8'hF0, 8'h5A, 0, 8'h00, 1'b0, 1'b0);
    vec[16] = mk(2, 8'hE0, 8'h75, 8'h00, 0, 8'h00, 1'b0, 1'b0);
    vec[17] = mk(2, 8'hF0, 8'h29, 8'h00, 0, 8'h00, 1'b0, 1'b0);
    vec[18] = mk(1, 8'h29, 8'h00, 8'h00, 1, 8'h20, 1'b0, 1'b0);
    vec[19] = mk(2, 8'hE0, 8'h4A, 8'h00, 1, 8'h2F, 1'b0, 1'b0);
    vec[20] = mk(1, 8'h66, 8'h00, 8'h00, 1, 8'h08, 1'b0, 1'b0);
    vec[21] = mk(1, 8'h0D, 8'h00, 8'h00, 1, 8'h09, 1'b0, 1'b0);
    vec[22] = mk(1, 8'h5A, 8'h00, 8'h00, 1, 8'h0D, 1'b0, 1'b0);
    vec[23] = mk(2, 8'hAA, 8'hFA, 8'h00, 0, 8'h00, 1'b0, 1'b0);
    vec[24] = mk(1, 8'h59, 8'h00, 8'h00, 0, 8'h00, 1'b1, 1'b0);
    vec[25] = mk(1, 8'h45, 8'h00, 8'h00, 1, 8'h29, 1'b1, 1'b0);
    vec[26] = mk(2, 8'hF0, 8'h59, 8'h00, 0, 8'h00, 1'b0, 1'b0);
    vec[27] = mk(3, 8'hF0, 8'h45, 8'h45, 1, 8'h30, 1'b0, 1'b0);
    vec[28] = mk(1, 8'h2C, 8'h00, 8'h00, 1, 8'h74, 1'b0, 1'b0);
    vec[29] = mk(1, 8'h1A, 8'h00, 8'h00, 1, 8'h7A, 1'b0, 1'b0);
    vec[30] = mk(1, 8'h15, 8'h00, 8'h00, 1, 8'h71, 1'b0, 1'b0);
    vec[31] = mk(1, 8'h4D, 8'h00, 8'h00, 1, 8'h70, 1'b0, 1'b0);
    vec[32] = mk(1, 8'h46, 8'h00, 8'h00, 1, 8'h39, 1'b0, 1'b0);

    codes   = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    letters = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
`ifdef PS2_REPEAT_FILTER_EN
    exp_rep = 1;
`else
    exp_rep = 3;
`endif

    // Reset state
    do_reset();
    chk("rst valid", {31'd0, ascii_valid}, 32'd0);
    chk("rst count", 32'(fifo_count), 32'd0);
    chk("rst caps", {31'd0, caps_lock}, 32'd0);
    chk("rst overflow", {31'd0, overflow}, 32'd0);
    chk("rst shift", {31'd0, shift_active}, 32'd0);
    chk("rst data", {24'd0, ascii_data}, 32'd0);

    // Reset mid-sequence drops prefix, modifiers and buffered chars
    send(8'h12);
    send(8'h1C);
    send(8'hF0);
    chk("mid pre count", 32'(fifo_count), 32'd1);
    do_reset();
    chk("mid rst count", 32'(fifo_count), 32'd0);
    chk("mid rst shift", {31'd0, shift_active}, 32'd0);
    send(8'h1C);
    expq.push_back(8'h61);
    chk("mid post count", 32'(fifo_count), 32'd1);
    drain("mid");
    send(8'hF0);
    send(8'h1C);

    // Table-driven decode vectors
    for (int i = 0; i < NV; i++) begin
      for (int j = 0; j < vec[i].nb; j++) begin
        send(vec[i].b[j]);
      end
      chk($sformatf("v%0d count", i), 32'(fifo_count), 32'(vec[i].nch));
      chk($sformatf("v%0d valid", i), {31'd0, ascii_valid}, {31'd0, (vec[i].nch != 0)});
      if (vec[i].nch != 0) begin
        chk($sformatf("v%0d data", i), {24'd0, ascii_data}, {24'd0, vec[i].ch});
        pop1();
      end
      chk($sformatf("v%0d shift", i), {31'd0, shift_active}, {31'd0, vec[i].sh});
      chk($sformatf("v%0d caps", i), {31'd0, caps_lock}, {31'd0, vec[i].cp});
    end

    // Typematic repeats
    send(8'h1C);
    send(8'h1C);
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    chk("rep count", 32'(fifo_count), 32'(exp_rep));
    for (int i = 0; i < exp_rep; i++) expq.push_back(8'h61);
    drain("rep");

    // Back-to-back strobes are each processed
    @(negedge clk);
    scan_code = 8'h12; scan_valid = 1'b1;
    @(negedge clk);
    scan_code = 8'h1C;
    @(negedge clk);
    scan_code = 8'hF0;
    @(negedge clk);
    scan_code = 8'h12;
    @(negedge clk);
    scan_valid = 1'b0;
    chk("b2b shift", {31'd0, shift_active}, 32'd0);
    expq.push_back(8'h41);
    drain("b2b");
    send(8'hF0);
    send(8'h1C);

    // Overflow: DEPTH+1 pushes without reads
    for (int i = 0; i < DEPTH + 1; i++) send(codes[i]);
    chk("ovf count", 32'(fifo_count), 32'(DEPTH));
    chk("ovf flag", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < DEPTH; i++) expq.push_back(letters[i]);
    drain("ovf");
    chk("ovf sticky", {31'd0, overflow}, 32'd1);
    @(negedge clk);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    chk("ovf clear", {31'd0, overflow}, 32'd0);

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < DEPTH; i++) send(codes[i]);
    chk("full count", 32'(fifo_count), 32'(DEPTH));
    chk("full no ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    scan_code = codes[8]; scan_valid = 1'b1; ascii_ready = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0; ascii_ready = 1'b0;
    chk("pp count", 32'(fifo_count), 32'(DEPTH));
    chk("pp no ovf", {31'd0, overflow}, 32'd0);
    chk("pp head", {24'd0, ascii_data}, {24'd0, letters[1]});

    // Drop and clear in the same cycle: the drop wins
    @(negedge clk);
    scan_code = 8'h1C; scan_valid = 1'b1; clr_overflow = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0; clr_overflow = 1'b0;
    chk("setwin ovf", {31'd0, overflow}, 32'd1);
    chk("setwin count", 32'(fifo_count), 32'(DEPTH));
    for (int i = 1; i < DEPTH + 1; i++) expq.push_back(letters[i]);
    drain("pp");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
